// File: rtl/lc4_ooo_pkg.sv
// Shared sizing helpers and defaults for the LC4 out-of-order rename stage.
package lc4_ooo_pkg;

  localparam int unsigned N_ARCH_DEF     = 8;
  localparam int unsigned TAG_W_DEF      = 4;
  localparam int unsigned CKPT_DEPTH_DEF = 4;

  // Index width for an n-entry table; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned PW_DEF = idx_w(CKPT_DEPTH_DEF);

  typedef logic [PW_DEF-1:0] ckpt_ptr_t;

endpackage

// File: rtl/lc4_ckpt_ctrl.sv
// Checkpoint ring bookkeeping: head/tail/count, restore liveness, ack, full/empty and sticky error.
module lc4_ckpt_ctrl
  import lc4_ooo_pkg::*;
#(
  parameter  int unsigned CKPT_DEPTH = CKPT_DEPTH_DEF,
  localparam int unsigned PW         = idx_w(CKPT_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          gwe,
  input  logic          flush,
  input  logic          ckpt_req,
  input  logic          restore,
  input  logic [PW-1:0] restore_id,
  input  logic          release_ckpt,
  output logic          ckpt_ack,
  output logic          restore_hit_c,
  output logic [PW-1:0] ckpt_id,
  output logic          ckpt_full,
  output logic          ckpt_empty,
  output logic          ckpt_err
);

  logic [PW-1:0] head_q, head_d, tail_q, tail_d, dist_c;
  logic [PW:0]   count_q, count_d;
  logic          err_q, err_set_c, live_c, act_c, rel_ok_c, full_c, empty_c;

  always_comb begin
    dist_c        = restore_id - head_q;
    live_c        = {1'b0, dist_c} < count_q;
    full_c        = count_q == (PW+1)'(CKPT_DEPTH);
    empty_c       = count_q == '0;
    act_c         = gwe & ~flush;
    restore_hit_c = act_c & restore & live_c;
    rel_ok_c      = act_c & ~restore & release_ckpt & ~empty_c;
    // A release in the same cycle frees a slot, so a full ring can still accept.
    ckpt_ack      = act_c & ckpt_req & ~restore & (~full_c | rel_ok_c);
    err_set_c     = act_c & ((restore & ~live_c) | (~restore & release_ckpt & empty_c));

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (gwe && flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (restore_hit_c) begin
      tail_d = restore_id;
      if (release_ckpt && (dist_c != '0)) begin
        head_d  = head_q + PW'(1);
        count_d = {1'b0, dist_c - PW'(1)};
      end else begin
        count_d = {1'b0, dist_c};
      end
    end else begin
      head_d  = head_q + PW'(rel_ok_c);
      tail_d  = tail_q + PW'(ckpt_ack);
      count_d = count_q + (PW+1)'(ckpt_ack) - (PW+1)'(rel_ok_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_q | err_set_c;
    end
  end

  assign ckpt_id    = tail_q;
  assign ckpt_full  = full_c;
  assign ckpt_empty = empty_c;
  assign ckpt_err   = err_q;

endmodule

// File: rtl/lc4_rename_map_ckpt.sv
// Speculative arch->phys rename map with multi-port read/write and a checkpoint ring for recovery.
// Optional LC4_RENAME_BYPASS_EN forwards same-cycle writes onto the read ports.
module lc4_rename_map_ckpt
  import lc4_ooo_pkg::*;
#(
  parameter  int unsigned N_ARCH     = N_ARCH_DEF,
  parameter  int unsigned TAG_W      = TAG_W_DEF,
  parameter  int unsigned N_RD       = 3,
  parameter  int unsigned N_WR       = 2,
  parameter  int unsigned CKPT_DEPTH = CKPT_DEPTH_DEF,
  localparam int unsigned AW         = idx_w(N_ARCH),
  localparam int unsigned PW         = idx_w(CKPT_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  gwe,
  input  logic                  flush,
  input  logic [N_RD*AW-1:0]    rsel,
  output logic [N_RD*TAG_W-1:0] rpsel,
  input  logic [N_WR-1:0]       we,
  input  logic [N_WR*AW-1:0]    wsel,
  input  logic [N_WR*TAG_W-1:0] wpsel,
  input  logic                  ckpt_req,
  output logic                  ckpt_ack,
  output logic [PW-1:0]         ckpt_id,
  input  logic                  restore,
  input  logic [PW-1:0]         restore_id,
  input  logic                  release_ckpt,
  output logic                  ckpt_full,
  output logic                  ckpt_empty,
  output logic                  ckpt_err
);

  logic [TAG_W-1:0] map_q  [N_ARCH];
  logic [TAG_W-1:0] map_d  [N_ARCH];
  logic [TAG_W-1:0] snap_q [CKPT_DEPTH][N_ARCH];
  logic             restore_hit_c;

  lc4_ckpt_ctrl #(.CKPT_DEPTH(CKPT_DEPTH)) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .gwe          (gwe),
    .flush        (flush),
    .ckpt_req     (ckpt_req),
    .restore      (restore),
    .restore_id   (restore_id),
    .release_ckpt (release_ckpt),
    .ckpt_ack     (ckpt_ack),
    .restore_hit_c(restore_hit_c),
    .ckpt_id      (ckpt_id),
    .ckpt_full    (ckpt_full),
    .ckpt_empty   (ckpt_empty),
    .ckpt_err     (ckpt_err)
  );

  // Next map: flush > restore > writes; later (younger) ports override earlier ones.
  always_comb begin
    map_d = map_q;
    if (gwe && flush) begin
      for (int unsigned i = 0; i < N_ARCH; i++) map_d[i] = TAG_W'(i);
    end else if (gwe && restore) begin
      if (restore_hit_c) map_d = snap_q[restore_id];
    end else if (gwe) begin
      for (int unsigned k = 0; k < N_WR; k++) begin
        if (we[k]) map_d[wsel[k*AW +: AW]] = wpsel[k*TAG_W +: TAG_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_ARCH; i++) map_q[i] <= TAG_W'(i);
    end else begin
      map_q <= map_d;
    end
  end

  // Snapshot captures the map as it stood at the start of the cycle.
  always_ff @(posedge clk) begin
    if (ckpt_ack) snap_q[ckpt_id] <= map_q;
  end

  always_comb begin
    rpsel = '0;
    for (int unsigned j = 0; j < N_RD; j++) begin
      rpsel[j*TAG_W +: TAG_W] = map_q[rsel[j*AW +: AW]];
`ifdef LC4_RENAME_BYPASS_EN
      for (int unsigned k = 0; k < N_WR; k++) begin
        if (gwe && we[k] && !flush && !restore && (wsel[k*AW +: AW] == rsel[j*AW +: AW]))
          rpsel[j*TAG_W +: TAG_W] = wpsel[k*TAG_W +: TAG_W];
      end
`endif
    end
  end

endmodule
